// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits reply one cycle after the request; misses issue a single-word fetch
// to the memory controller, fill the line on its ok pulse, then reply.
// Rollback abandons an outstanding miss without filling the line.
module icache_direct #(
    parameter int INDEX_WIDTH = 7,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic                  in_fetch_ena,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    output logic                  out_fetch_ok,
    output logic [31:0]           out_fetch_inst,
    output logic                  out_mem_ena,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    input  logic                  in_mem_ok,
    input  logic [31:0]           in_mem_data
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        MISS_WAIT
    } state_t;

    state_t state, state_d;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [31:0]           data_q [LINES];

    logic [ADDR_WIDTH-1:0] pending_addr, pending_d;
    logic                  fetch_ok_d;
    logic [31:0]           fetch_inst_d;
    logic                  mem_ena_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic                  fill;

    logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]       req_tag, fill_tag;
    logic                   hit;

    assign req_idx  = in_fetch_addr[INDEX_WIDTH+1:2];
    assign req_tag  = in_fetch_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign fill_idx = pending_addr[INDEX_WIDTH+1:2];
    assign fill_tag = pending_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Next-state and next-output decode; rollback dominates everything but reset.
    always_comb begin
        state_d      = state;
        pending_d    = pending_addr;
        fetch_ok_d   = 1'b0;
        fetch_inst_d = out_fetch_inst;
        mem_ena_d    = 1'b0;
        mem_addr_d   = out_mem_addr;
        fill         = 1'b0;
        if (in_rollback) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && in_fetch_ena) begin
                        if (hit) begin
                            fetch_ok_d   = 1'b1;
                            fetch_inst_d = data_q[req_idx];
                        end else begin
                            pending_d = in_fetch_addr & ~(ADDR_WIDTH'(3));
                            state_d   = MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (ena) begin
                        mem_ena_d  = 1'b1;
                        mem_addr_d = pending_addr;
                        state_d    = MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    // Memory response is taken even with ena low so it is never lost.
                    if (in_mem_ok) begin
                        fill         = 1'b1;
                        fetch_ok_d   = 1'b1;
                        fetch_inst_d = in_mem_data;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, registered outputs and valid bits, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            pending_addr   <= '0;
            out_fetch_ok   <= 1'b0;
            out_fetch_inst <= '0;
            out_mem_ena    <= 1'b0;
            out_mem_addr   <= '0;
            valid_q        <= '0;
        end else begin
            state          <= state_d;
            pending_addr   <= pending_d;
            out_fetch_ok   <= fetch_ok_d;
            out_fetch_inst <= fetch_inst_d;
            out_mem_ena    <= mem_ena_d;
            out_mem_addr   <= mem_addr_d;
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents need no reset because valid bits guard them.
    always_ff @(posedge clk) begin
        if (rst && fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= in_mem_data;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        in_rollback;
    logic        in_fetch_ena;
    logic [31:0] in_fetch_addr;
    logic        out_fetch_ok;
    logic [31:0] out_fetch_inst;
    logic        out_mem_ena;
    logic [31:0] out_mem_addr;
    logic        in_mem_ok;
    logic [31:0] in_mem_data;

    int checks = 0;
    int errors = 0;

    icache_direct #(.INDEX_WIDTH(7), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .in_rollback    (in_rollback),
        .in_fetch_ena   (in_fetch_ena),
        .in_fetch_addr  (in_fetch_addr),
        .out_fetch_ok   (out_fetch_ok),
        .out_fetch_inst (out_fetch_inst),
        .out_mem_ena    (out_mem_ena),
        .out_mem_addr   (out_mem_addr),
        .in_mem_ok      (in_mem_ok),
        .in_mem_data    (in_mem_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] d);
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
        tick();
        in_fetch_ena  = 1'b0;
        check("hit_ok", 32'(out_fetch_ok), 32'd1);
        check("hit_inst", out_fetch_inst, d);
        check("hit_no_mem", 32'(out_mem_ena), 32'd0);
        tick();
        check("hit_ok_pulse", 32'(out_fetch_ok), 32'd0);
    endtask

    task automatic fetch_miss(input logic [31:0] a, input logic [31:0] d);
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
        tick();
        in_fetch_ena  = 1'b0;
        check("miss_no_ok", 32'(out_fetch_ok), 32'd0);
        check("miss_no_mem_yet", 32'(out_mem_ena), 32'd0);
        tick();
        check("miss_mem_ena", 32'(out_mem_ena), 32'd1);
        check("miss_mem_addr", out_mem_addr, a & 32'hFFFF_FFFC);
        tick();
        check("miss_mem_pulse", 32'(out_mem_ena), 32'd0);
        in_mem_ok   = 1'b1;
        in_mem_data = d;
        tick();
        in_mem_ok   = 1'b0;
        check("fill_ok", 32'(out_fetch_ok), 32'd1);
        check("fill_inst", out_fetch_inst, d);
        tick();
        check("fill_ok_pulse", 32'(out_fetch_ok), 32'd0);
        check("fill_inst_hold", out_fetch_inst, d);
    endtask

    initial begin
        rst           = 1'b0;
        ena           = 1'b1;
        in_rollback   = 1'b0;
        in_fetch_ena  = 1'b0;
        in_fetch_addr = '0;
        in_mem_ok     = 1'b0;
        in_mem_data   = '0;
        tick();
        tick();
        check("rst_ok", 32'(out_fetch_ok), 32'd0);
        check("rst_inst", out_fetch_inst, 32'd0);
        check("rst_mem_ena", 32'(out_mem_ena), 32'd0);
        check("rst_mem_addr", out_mem_addr, 32'd0);
        rst = 1'b1;
        tick();

        // Cold miss then hit
        fetch_miss(32'h0000_0000, 32'h0000_0013);
        fetch_hit(32'h0000_0000, 32'h0000_0013);

        // Same index, different tag evicts
        fetch_miss(32'h0000_0200, 32'hDEAD_BEEF);
        fetch_hit(32'h0000_0200, 32'hDEAD_BEEF);
        fetch_miss(32'h0000_0000, 32'h0000_0013);

        // Rollback in MISS_WAIT concurrent with in_mem_ok: no fill, no reply
        in_fetch_ena  = 1'b1;
        in_fetch_addr = 32'h0000_0104;
        tick();
        in_fetch_ena  = 1'b0;
        tick();
        check("rb_mem_ena", 32'(out_mem_ena), 32'd1);
        check("rb_mem_addr", out_mem_addr, 32'h0000_0104);
        tick();
        in_rollback = 1'b1;
        in_mem_ok   = 1'b1;
        in_mem_data = 32'h1234_5678;
        tick();
        in_rollback = 1'b0;
        in_mem_ok   = 1'b0;
        check("rb_no_ok", 32'(out_fetch_ok), 32'd0);
        check("rb_inst_hold", out_fetch_inst, 32'h0000_0013);
        tick();
        check("rb_no_ok_late", 32'(out_fetch_ok), 32'd0);
        fetch_miss(32'h0000_0104, 32'hCAFE_0104);

        // Rollback in MISS_REQ suppresses the memory request
        in_fetch_ena  = 1'b1;
        in_fetch_addr = 32'h0000_0400;
        tick();
        in_fetch_ena  = 1'b0;
        in_rollback   = 1'b1;
        tick();
        in_rollback   = 1'b0;
        check("rbreq_no_mem", 32'(out_mem_ena), 32'd0);
        check("rbreq_addr_hold", out_mem_addr, 32'h0000_0104);
        tick();
        check("rbreq_no_mem_late", 32'(out_mem_ena), 32'd0);

        // ena=0 in IDLE drops the request
        ena           = 1'b0;
        in_fetch_ena  = 1'b1;
        in_fetch_addr = 32'h0000_0000;
        tick();
        in_fetch_ena  = 1'b0;
        check("ena0_no_ok", 32'(out_fetch_ok), 32'd0);
        tick();
        check("ena0_no_mem", 32'(out_mem_ena), 32'd0);
        ena = 1'b1;
        in_fetch_addr = 32'h0000_0800;
        tick();
        check("ena0_idle_no_mem", 32'(out_mem_ena), 32'd0);

        // ena=0 stalls MISS_REQ; in MISS_WAIT the response is still honoured
        in_fetch_ena  = 1'b1;
        in_fetch_addr = 32'h0000_0302;
        tick();
        in_fetch_ena  = 1'b0;
        ena           = 1'b0;
        tick();
        check("stall_no_mem", 32'(out_mem_ena), 32'd0);
        ena = 1'b1;
        tick();
        check("stall_mem_ena", 32'(out_mem_ena), 32'd1);
        check("stall_mem_addr", out_mem_addr, 32'h0000_0300);
        ena         = 1'b0;
        in_mem_ok   = 1'b1;
        in_mem_data = 32'h0BAD_F00D;
        tick();
        in_mem_ok   = 1'b0;
        check("ena0_wait_ok", 32'(out_fetch_ok), 32'd1);
        check("ena0_wait_inst", out_fetch_inst, 32'h0BAD_F00D);
        ena = 1'b1;
        tick();
        fetch_hit(32'h0000_0300, 32'h0BAD_F00D);

        // Reset overrides a hit in the same cycle and invalidates all lines
        in_fetch_ena  = 1'b1;
        in_fetch_addr = 32'h0000_0300;
        rst           = 1'b0;
        tick();
        in_fetch_ena  = 1'b0;
        rst           = 1'b1;
        check("rst2_ok", 32'(out_fetch_ok), 32'd0);
        check("rst2_inst", out_fetch_inst, 32'd0);
        check("rst2_mem_ena", 32'(out_mem_ena), 32'd0);
        check("rst2_mem_addr", out_mem_addr, 32'd0);
        fetch_miss(32'h0000_0300, 32'h1111_2222);
        fetch_miss(32'h0000_0104, 32'h3333_4444);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
